// File: rtl/ysyx_24110006_alu_pkg.sv
// ---------------------------------------------------------------------------
// ysyx_24110006_alu_pkg
// Shared constants for the execute-side ALU:
//   - func3 encodings for the register/immediate ALU ops and for branches
//   - FSM state encoding of the output stage
//   - helper that tells whether an op type selects the shifter
// Optional feature macro used by the files importing this package:
//   YSYX_24110006_ALU_SERIAL_SHIFT_EN (iterative 1-bit/cycle shifter)
// ---------------------------------------------------------------------------
package ysyx_24110006_alu_pkg;

   // Non-branch ops, selected by func3 when op type bit 3 is clear
   localparam logic [2:0] ALU_ADD  = 3'b000;
   localparam logic [2:0] ALU_SLL  = 3'b001;
   localparam logic [2:0] ALU_SLT  = 3'b010;
   localparam logic [2:0] ALU_SLTU = 3'b011;
   localparam logic [2:0] ALU_XOR  = 3'b100;
   localparam logic [2:0] ALU_SR   = 3'b101;
   localparam logic [2:0] ALU_OR   = 3'b110;
   localparam logic [2:0] ALU_AND  = 3'b111;

   // Branch conditions, selected by func3 when op type bit 3 is set
   localparam logic [2:0] BR_BEQ  = 3'b000;
   localparam logic [2:0] BR_BNE  = 3'b001;
   localparam logic [2:0] BR_BLT  = 3'b100;
   localparam logic [2:0] BR_BGE  = 3'b101;
   localparam logic [2:0] BR_BLTU = 3'b110;
   localparam logic [2:0] BR_BGEU = 3'b111;

   // IDLE: output register empty; SHIFT: serial shift running; FULL: result valid
   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_FULL  = 2'd2
   } state_t;

   // True for SLL / SRL / SRA (non-branch op types routed through the shifter)
   function automatic logic isShiftOp(input logic [3:0] t);
      return !t[3] && ((t[2:0] == ALU_SLL) || (t[2:0] == ALU_SR));
   endfunction

endpackage

// File: rtl/ysyx_24110006_alu_shifter.sv
// ---------------------------------------------------------------------------
// ysyx_24110006_alu_shifter
// 32-bit shifter for SLL / SRL / SRA.
//   Macro YSYX_24110006_ALU_SERIAL_SHIFT_EN defined: iterative shifter, one bit
//   per cycle, 5-bit down counter. i_start loads the operand (only issued with
//   a non-zero shift amount); o_done rises in the cycle whose next edge
//   produces the final value, and o_result then carries that final value.
//   When idle, o_result passes i_a through (shift amount of zero).
//   Macro undefined: combinational barrel shifter, o_done is always 1.
// Ports:
//   clock, reset      clock and asynchronous active-high reset
//   i_start           begin a serial shift (ignored by the barrel version)
//   i_a               value to shift
//   i_shamt           shift amount
//   i_left            1 = left shift, 0 = right shift
//   i_arith           right shifts replicate the sign bit
//   o_result          shifted value
//   o_done            shift result available on o_result
// ---------------------------------------------------------------------------
module ysyx_24110006_alu_shifter
   import ysyx_24110006_alu_pkg::*;
(
   input  logic        clock,
   input  logic        reset,
   input  logic        i_start,
   input  logic [31:0] i_a,
   input  logic [4:0]  i_shamt,
   input  logic        i_left,
   input  logic        i_arith,
   output logic [31:0] o_result,
   output logic        o_done
);

`ifdef YSYX_24110006_ALU_SERIAL_SHIFT_EN

   logic        r_busy;
   logic [4:0]  r_cnt;
   logic [31:0] r_data;
   logic        r_left;
   logic        r_arith;
   logic [31:0] w_step;

   // One-bit step applied to the working value each busy cycle
   always_comb begin
      if (r_left) begin
         w_step = {r_data[30:0], 1'b0};
      end else begin
         w_step = {r_arith & r_data[31], r_data[31:1]};
      end
   end

   // Load on start, then shift and count down until the counter expires
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_busy  <= 1'b0;
         r_cnt   <= 5'd0;
         r_data  <= 32'd0;
         r_left  <= 1'b0;
         r_arith <= 1'b0;
      end else if (i_start && !r_busy) begin
         r_busy  <= (i_shamt != 5'd0);
         r_cnt   <= i_shamt;
         r_data  <= i_a;
         r_left  <= i_left;
         r_arith <= i_arith;
      end else if (r_busy) begin
         r_data <= w_step;
         r_cnt  <= r_cnt - 5'd1;
         if (r_cnt == 5'd1) begin
            r_busy <= 1'b0;
         end
      end
   end

   assign o_result = r_busy ? w_step : i_a;
   assign o_done   = r_busy ? (r_cnt == 5'd1) : 1'b1;

`else

   logic w_unused;

   // Single-cycle barrel shifter; clock, reset and start are not needed
   always_comb begin
      if (i_left) begin
         o_result = i_a << i_shamt;
      end else if (i_arith) begin
         o_result = $unsigned($signed(i_a) >>> i_shamt);
      end else begin
         o_result = i_a >> i_shamt;
      end
   end

   assign o_done   = 1'b1;
   assign w_unused = &{1'b0, clock, reset, i_start};

`endif

endmodule

// File: rtl/ysyx_24110006_alu_exec.sv
// ---------------------------------------------------------------------------
// ysyx_24110006_alu_exec
// Execute-stage ALU: consumes the pre-muxed operand bundle from decode,
// computes the integer result and branch decision, and holds them in an
// output register until the writeback/branch unit takes them.
// Macro YSYX_24110006_ALU_SERIAL_SHIFT_EN selects the iterative shifter
// (variable shift latency); default build uses a barrel shifter (latency 1).
// Ports:
//   clock, reset          clock and asynchronous active-high reset
//   i_valid / o_ready     input handshake for the operand bundle
//   i_alu_a, i_alu_b      operands (b already inverted for subtract-class ops)
//   i_alu_sub             adder carry-in
//   i_alu_sign            signed compare select
//   i_alu_t               {is_branch, func3}
//   i_alu_sra             arithmetic right shift
//   o_valid / i_ready     output handshake for the result
//   o_result              ALU result, or {31'b0, taken} for branches
//   o_taken               branch condition (0 for non-branch ops)
// ---------------------------------------------------------------------------
module ysyx_24110006_alu_exec
   import ysyx_24110006_alu_pkg::*;
(
   input  logic        clock,
   input  logic        reset,
   input  logic        i_valid,
   output logic        o_ready,
   input  logic [31:0] i_alu_a,
   input  logic [31:0] i_alu_b,
   input  logic        i_alu_sub,
   input  logic        i_alu_sign,
   input  logic [3:0]  i_alu_t,
   input  logic        i_alu_sra,
   output logic        o_valid,
   input  logic        i_ready,
   output logic [31:0] o_result,
   output logic        o_taken
);

   state_t      r_state;
   logic [31:0] r_result;
   logic        r_taken;

   logic [32:0] w_sum;
   logic        w_bSign;
   logic        w_ltu;
   logic        w_lt;
   logic        w_less;
   logic        w_eq;
   logic        w_accept;
   logic        w_goShift;
   logic        w_shStart;
   logic [31:0] w_shResult;
   logic        w_shDone;
   logic [31:0] w_aluResult;
   logic        w_taken;

   // Shared adder; compares reuse it with b pre-inverted and carry-in of 1.
   // The sign of the original b decides whether the signed compare can be
   // taken straight from a's sign bit (operands of opposite sign).
   assign w_sum   = {1'b0, i_alu_a} + {1'b0, i_alu_b} + {32'd0, i_alu_sub};
   assign w_bSign = i_alu_sub ? ~i_alu_b[31] : i_alu_b[31];
   assign w_ltu   = ~w_sum[32];
   assign w_lt    = (i_alu_a[31] != w_bSign) ? i_alu_a[31] : w_sum[31];
   assign w_less  = i_alu_sign ? w_lt : w_ltu;
   assign w_eq    = (w_sum[31:0] == 32'd0);

   assign w_accept  = i_valid && o_ready;
   assign w_shStart = w_accept && w_goShift;

`ifdef YSYX_24110006_ALU_SERIAL_SHIFT_EN
   assign w_goShift = isShiftOp(i_alu_t) && (i_alu_b[4:0] != 5'd0);
`else
   assign w_goShift = 1'b0;
`endif

   ysyx_24110006_alu_shifter u_shifter (
      .clock    (clock),
      .reset    (reset),
      .i_start  (w_shStart),
      .i_a      (i_alu_a),
      .i_shamt  (i_alu_b[4:0]),
      .i_left   (i_alu_t[2:0] == ALU_SLL),
      .i_arith  (i_alu_sra),
      .o_result (w_shResult),
      .o_done   (w_shDone)
   );

   // Result and branch-decision selection for single-cycle completion
   always_comb begin
      w_taken     = 1'b0;
      w_aluResult = 32'd0;
      if (i_alu_t[3]) begin
         case (i_alu_t[2:0])
            BR_BEQ:           w_taken = w_eq;
            BR_BNE:           w_taken = ~w_eq;
            BR_BLT, BR_BLTU:  w_taken = w_less;
            BR_BGE, BR_BGEU:  w_taken = ~w_less;
            default:          w_taken = 1'b0;
         endcase
         w_aluResult = {31'd0, w_taken};
      end else begin
         case (i_alu_t[2:0])
            ALU_ADD:           w_aluResult = w_sum[31:0];
            ALU_SLL, ALU_SR:   w_aluResult = w_shResult;
            ALU_SLT, ALU_SLTU: w_aluResult = {31'd0, w_less};
            ALU_XOR:           w_aluResult = i_alu_a ^ i_alu_b;
            ALU_OR:            w_aluResult = i_alu_a | i_alu_b;
            default:           w_aluResult = i_alu_a & i_alu_b;
         endcase
      end
   end

   // Output-stage FSM. An accept always wins: it either fills the output
   // register directly (replacing a result consumed on the same edge) or
   // starts a serial shift. Without an accept, a consumed result empties the
   // register and a finishing serial shift fills it.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_state  <= ST_IDLE;
         r_result <= 32'd0;
         r_taken  <= 1'b0;
      end else if (w_accept) begin
         if (w_goShift) begin
            r_state <= ST_SHIFT;
         end else begin
            r_state  <= ST_FULL;
            r_result <= w_aluResult;
            r_taken  <= w_taken;
         end
      end else begin
         case (r_state)
            ST_FULL: begin
               if (i_ready) begin
                  r_state <= ST_IDLE;
               end
            end
            ST_SHIFT: begin
               if (w_shDone) begin
                  r_state  <= ST_FULL;
                  r_result <= w_shResult;
                  r_taken  <= 1'b0;
               end
            end
            default: begin
            end
         endcase
      end
   end

   assign o_ready  = (r_state == ST_IDLE) || ((r_state == ST_FULL) && i_ready);
   assign o_valid  = (r_state == ST_FULL);
   assign o_result = r_result;
   assign o_taken  = r_taken;

endmodule

// File: doc/ysyx_24110006_alu_exec.md
# ysyx_24110006_alu_exec

Execute-side consumer of the operand/control bundle produced by the decode-stage ALU operand selector. Accepts pre-muxed operands (`b` already inverted for subtract-class ops) plus `sub/sign/t/sra` controls over a valid/ready handshake. Computes the integer result and the branch decision, then holds them in an output register until the writeback/branch unit takes them. Sits between IDU and LSU/WBU in the NPC pipeline.

## Interface
Parameters:
- none (width fixed at 32)

Ports:
- `clock`  in  1  single clock, rising edge
- `reset`  in  1  asynchronous, active-high
- `i_valid`  in  1  operand bundle valid
- `o_ready`  out  1  block can accept a bundle this cycle
- `i_alu_a`  in  32  operand A
- `i_alu_b`  in  32  operand B; already bit-inverted when `i_alu_sub`=1
- `i_alu_sub`  in  1  add carry-in of 1 (subtract/compare)
- `i_alu_sign`  in  1  signed compare
- `i_alu_t`  in  4  op type: {is_branch, func3}
- `i_alu_sra`  in  1  arithmetic right shift
- `o_valid`  out  1  result valid
- `i_ready`  in  1  downstream accepts result
- `o_result`  out  32  ALU result (branch ops: {31'b0, taken})
- `o_taken`  out  1  branch condition true (0 for non-branch)

## Operation
- Adder: `sum = a + b + sub` (33-bit; `cout` = bit 32). `borig = sub ? ~b : b`.
- Unsigned less: `ltu = ~cout` (valid only when sub=1). Signed less: `lt = (a[31]!=borig[31]) ? a[31] : sum[31]`. `less = sign ? lt : ltu`. `eq = (sum[31:0]==0)`.
- Non-branch (t[3]=0), by t[2:0]: 000 sum; 001 `a << b[4:0]`; 010/011 {31'b0,less}; 100 a^b; 101 `a >> b[4:0]`, arithmetic if `sra`; 110 a|b; 111 a&b.
- Branch (t[3]=1), by t[2:0]: 000 eq; 001 !eq; 100/110 less; 101/111 !less; 010/011 taken=0.
- Transfer in: `i_valid && o_ready`. Transfer out: `o_valid && i_ready`.
- FSM states: IDLE (output register empty), SHIFT (serial shift in progress, only with macro), FULL (o_valid=1).
  - IDLE/FULL-with-i_ready + accept, non-shift or barrel -> FULL, result registered.
  - accept of a shift with macro and shamt>0 -> SHIFT; counter = shamt.
  - SHIFT: one bit per cycle; counter reaches 0 -> FULL.
  - FULL & i_ready & no accept -> IDLE.
- `o_ready = (state==IDLE) || (state==FULL && i_ready)` — full throughput for 1-cycle ops.
- Output register and `o_taken` stable while `o_valid && !i_ready`.

## Timing
- Reset values: `o_valid`=0, `o_result`=0, `o_taken`=0, state IDLE, so `o_ready`=1 after reset.
- Latency: accept at edge N -> `o_valid`=1 in cycle N+1 (all ops without macro; non-shift or shamt=0 with macro).
- Serial shift of k>0 (macro on): `o_ready`=0 for k cycles, `o_valid` in cycle N+1+k.
- Back-to-back: consume and accept on the same edge keeps `o_valid`=1 with the new result.
- Reset mid-SHIFT or with FULL: state aborted, `o_valid` drops asynchronously, no partial result emitted.
- No combinational path from `i_valid` to `o_ready`; `i_ready` -> `o_ready` path is allowed.

## Configuration
- `YSYX_24110006_ALU_SERIAL_SHIFT_EN` defined: shifts use an iterative 1-bit/cycle shifter (area-saving, SHIFT state active, variable latency).
- Undefined: single-cycle barrel shifter, SHIFT state and counter absent, every op has latency 1.

## Structure
- Package `ysyx_24110006_alu_pkg`: func3 localparams (ADD, SLL, SLT, SLTU, XOR, SR, OR, AND; BEQ..BGEU), state enum (IDLE, SHIFT, FULL).
- Sub-module `ysyx_24110006_alu_shifter`: barrel or serial implementation selected by the macro; start/done interface, 5-bit counter when serial.
- Top holds adder, compare, logic ops, FSM and output register.

## Test plan
- Reset asserted mid-transfer -> `o_valid`=0, `o_result`=0, `o_ready`=1 immediately.
- a=5, b=~3, sub=1, t=0000 -> result 2 in cycle N+1; a=3, b=~5, sub=1, sign=1, t=0010 -> result 1.
- Branch a=0xFFFFFFFF, b=~1, sub=1: t=1100 sign=1 -> taken=1; t=1110 sign=0 -> taken=0; a=b=7, t=1000 -> taken=1.
- a=0x80000000, b=4, t=0101, sra=1 -> 0xF8000000; sra=0 -> 0x08000000; with macro, `o_ready`=0 for 4 cycles, valid at N+5.
- `i_ready`=0 for 3 cycles with result 0x1234 -> `o_result` held, `o_ready`=0; release -> one transfer, no duplication.
- Continuous stream of 8 ADDs with `i_ready`=1 -> one result per cycle, in order, no bubbles.
